// File: rtl/cmd_pkg.sv
// Shared definitions for the command decoder: entry layout, kind and register
// codes, and the small helpers used to classify controller write enables.
package cmd_pkg;

  localparam int ENTRY_W = 6;

  localparam logic KIND_WRITE = 1'b0;
  localparam logic KIND_STORE = 1'b1;

  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_B = 3'd1;
  localparam logic [2:0] REG_C = 3'd2;
  localparam logic [2:0] REG_D = 3'd3;
  localparam logic [2:0] REG_E = 3'd4;
  localparam logic [2:0] REG_F = 3'd5;
  localparam logic [2:0] REG_G = 3'd6;
  localparam logic [2:0] REG_H = 3'd7;

  typedef enum logic [1:0] {
    CLS_IDLE,
    CLS_WRITE,
    CLS_STORE,
    CLS_ILLEGAL
  } cmd_class_e;

  typedef struct packed {
    logic       kind;
    logic [2:0] reg_idx;
    logic [1:0] sel;
  } cmd_entry_t;

  function automatic logic [3:0] we_popcount(input logic [7:0] we);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(we[i]);
    end
    return cnt;
  endfunction

  // Only meaningful for one-hot input; anything else maps to REG_A.
  function automatic logic [2:0] we_index(input logic [7:0] we);
    logic [2:0] idx;
    case (we)
      8'h01:   idx = REG_A;
      8'h02:   idx = REG_B;
      8'h04:   idx = REG_C;
      8'h08:   idx = REG_D;
      8'h10:   idx = REG_E;
      8'h20:   idx = REG_F;
      8'h40:   idx = REG_G;
      8'h80:   idx = REG_H;
      default: idx = REG_A;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for decoded command entries. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module cmd_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] data_in,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               empty,
  output logic               full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               pop_en;
  logic               push_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO only lands if the head leaves on the same edge.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cmd_decoder.sv
// Decodes the sequencing controller's command strobes into WRITE/STORE records,
// flags protocol violations and queues legal commands for a downstream consumer.
module cmd_decoder
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             data_we,
  input  logic [7:0]       we,
  input  logic [1:0]       jklm_select,
  input  logic             err_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_kind,
  output logic [2:0]       out_reg,
  output logic [1:0]       out_sel,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_multi_we,
  output logic             err_store_we,
  output logic             overflow
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  cmd_class_e cls_p0;
  cmd_entry_t entry_p0;
  logic [3:0] we_cnt_p0;
  logic       multi_p0;
  logic       store_we_p0;
  logic       legal_p0;
  logic       illegal_p0;
  logic       ovf_p0;

  cmd_entry_t head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;

  always_comb begin
    cls_p0      = CLS_ILLEGAL;
    entry_p0    = '0;
    we_cnt_p0   = we_popcount(we);
    multi_p0    = (we_cnt_p0 > 4'd1);
    store_we_p0 = data_we && (we != 8'h00);
    if (!data_we && (we == 8'h00)) begin
      cls_p0 = CLS_IDLE;
    end else if (!data_we && (we_cnt_p0 == 4'd1)) begin
      cls_p0           = CLS_WRITE;
      entry_p0.kind    = KIND_WRITE;
      entry_p0.reg_idx = we_index(we);
    end else if (data_we && (we == 8'h00)) begin
      cls_p0           = CLS_STORE;
      entry_p0.kind    = KIND_STORE;
      entry_p0.reg_idx = REG_A;
      entry_p0.sel     = jklm_select;
    end
  end

  assign legal_p0   = (cls_p0 == CLS_WRITE) || (cls_p0 == CLS_STORE);
  assign illegal_p0 = (cls_p0 == CLS_ILLEGAL);
  assign pop        = out_valid && out_ready;
  assign ovf_p0     = legal_p0 && fifo_full && !pop;

  // ---- stage boundary: decoded sample enters the queue ----
  cmd_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .push    (legal_p0),
    .data_in (entry_p0),
    .pop     (pop),
    .head    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_kind  = head.kind & out_valid;
  assign out_reg   = head.reg_idx & {3{out_valid}};
  assign out_sel   = head.sel & {2{out_valid}};

  // Counters and sticky flags share the decode edge; a fresh error beats err_clr.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cmd_count    <= '0;
      err_count    <= '0;
      err_multi_we <= 1'b0;
      err_store_we <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (legal_p0) cmd_count <= sat_inc(cmd_count);

      if (illegal_p0)   err_count <= err_clr ? CNT_W'(1) : sat_inc(err_count);
      else if (err_clr) err_count <= '0;

      err_multi_we <= (err_multi_we && !err_clr) || (illegal_p0 && multi_p0);
      err_store_we <= (err_store_we && !err_clr) || (illegal_p0 && store_we_p0);
      overflow     <= (overflow && !err_clr) || ovf_p0;
    end
  end

endmodule
